// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD MM:SS countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam int          DIGIT_W   = 4;
  localparam logic [3:0]  DIGIT_MAX = 4'd9;
  localparam logic [3:0]  SEC_T_MAX = 4'd5;

  typedef struct packed {
    logic [DIGIT_W-1:0] min_t;
    logic [DIGIT_W-1:0] min_u;
    logic [DIGIT_W-1:0] sec_t;
    logic [DIGIT_W-1:0] sec_u;
  } bcd_time_t;

  localparam bcd_time_t TIME_ZERO = 16'h0000;
  localparam bcd_time_t TIME_ONE  = 16'h0001;

  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d,
                                                     input logic [DIGIT_W-1:0] lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of a down-counter: decrements on borrow_in, wrapping 0 -> wrap.
import timer_pkg::*;

module bcd_digit_down (
  input  logic [DIGIT_W-1:0] digit,
  input  logic               borrow_in,
  input  logic [DIGIT_W-1:0] wrap,
  output logic [DIGIT_W-1:0] next_digit,
  output logic               borrow_out
);

  // Decrement with wrap and borrow propagation
  always_comb begin
    next_digit = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        next_digit = wrap;
        borrow_out = 1'b1;
      end else begin
        next_digit = digit - 4'd1;
        borrow_out = 1'b0;
      end
    end else begin
      next_digit = digit;
      borrow_out = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer driven by a 1 Hz tick pulse, with pause, expiry
// flagging and optional auto-reload of the stored preset.
import timer_pkg::*;

module bcd_countdown_timer #(
  parameter bit AUTO_RELOAD  = 1'b0,
  parameter int MAX_MIN_TENS = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_i,
  input  logic       load,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [7:0] min_o,
  output logic [7:0] sec_o,
  output logic       running,
  output logic       tick_en,
  output logic       expired,
  output logic       alarm
);

  localparam logic [3:0] MIN_T_MAX = MAX_MIN_TENS[3:0];

  state_t    state_r, state_s;
  bcd_time_t count_r, count_s, preset_r, preset_s, dec_s, clamped_s;
  logic      alarm_r, alarm_s, expired_r, expired_s, running_r;
  logic      reload_pend_r, reload_pend_s;
  logic      b_su_s, b_st_s, b_mu_s, b_mt_s;

  // A borrow out of the top digit means the count is 00:00 and must not move.
  bcd_digit_down u_sec_u (.digit(count_r.sec_u), .borrow_in(1'b1), .wrap(DIGIT_MAX),
                          .next_digit(dec_s.sec_u), .borrow_out(b_su_s));
  bcd_digit_down u_sec_t (.digit(count_r.sec_t), .borrow_in(b_su_s), .wrap(SEC_T_MAX),
                          .next_digit(dec_s.sec_t), .borrow_out(b_st_s));
  bcd_digit_down u_min_u (.digit(count_r.min_u), .borrow_in(b_st_s), .wrap(DIGIT_MAX),
                          .next_digit(dec_s.min_u), .borrow_out(b_mu_s));
  bcd_digit_down u_min_t (.digit(count_r.min_t), .borrow_in(b_mu_s), .wrap(MIN_T_MAX),
                          .next_digit(dec_s.min_t), .borrow_out(b_mt_s));

  assign clamped_s.min_t = clamp_digit(preset_min[7:4], MIN_T_MAX);
  assign clamped_s.min_u = clamp_digit(preset_min[3:0], DIGIT_MAX);
  assign clamped_s.sec_t = clamp_digit(preset_sec[7:4], SEC_T_MAX);
  assign clamped_s.sec_u = clamp_digit(preset_sec[3:0], DIGIT_MAX);

  // Next-state logic, priority clear > load > stop > start > tick
  always_comb begin
    state_s       = state_r;
    count_s       = reload_pend_r ? preset_r : count_r;
    preset_s      = preset_r;
    alarm_s       = alarm_r;
    expired_s     = 1'b0;
    reload_pend_s = 1'b0;
    if (clear) begin
      state_s  = ST_IDLE;
      count_s  = TIME_ZERO;
      preset_s = TIME_ZERO;
      alarm_s  = 1'b0;
    end else if (load) begin
      state_s  = ST_IDLE;
      count_s  = clamped_s;
      preset_s = clamped_s;
      alarm_s  = 1'b0;
    end else if (stop) begin
      if (state_r == ST_RUN) begin
        state_s = ST_PAUSE;
      end else begin
        state_s = state_r;
      end
    end else if (start) begin
      case (state_r)
        ST_IDLE, ST_PAUSE: state_s = (count_r != TIME_ZERO) ? ST_RUN : state_r;
        ST_EXPIRED: begin
          count_s = preset_r;
          alarm_s = 1'b0;
          state_s = (preset_r != TIME_ZERO) ? ST_RUN : ST_IDLE;
        end
        default: state_s = state_r;
      endcase
    end else if (tick_i && (state_r == ST_RUN) && !reload_pend_r && !b_mt_s) begin
      count_s = dec_s;
      if (count_r == TIME_ONE) begin
        expired_s = 1'b1;
        if (AUTO_RELOAD && (preset_r != TIME_ZERO)) begin
          reload_pend_s = 1'b1;
        end else begin
          state_s = ST_EXPIRED;
          alarm_s = 1'b1;
        end
      end else begin
        expired_s = 1'b0;
      end
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      count_r       <= TIME_ZERO;
      preset_r      <= TIME_ZERO;
      alarm_r       <= 1'b0;
      expired_r     <= 1'b0;
      running_r     <= 1'b0;
      reload_pend_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      count_r       <= count_s;
      preset_r      <= preset_s;
      alarm_r       <= alarm_s;
      expired_r     <= expired_s;
      running_r     <= (state_s == ST_RUN);
      reload_pend_r <= reload_pend_s;
    end
  end

  assign min_o   = {count_r.min_t, count_r.min_u};
  assign sec_o   = {count_r.sec_t, count_r.sec_u};
  assign running = running_r;
  assign tick_en = running_r;
  assign expired = expired_r;
  assign alarm   = alarm_r;

endmodule
